readout_tx_meas_sequencer: RTL and testbench

READOUT_TX_MEAS_SEQUENCER -- requirements
Module: readout_tx_meas_sequencer

---
 rtl/readout_tx_meas_sequencer.sv | 147 ++++++++++++++
 tb/tb_readout_tx_meas_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/readout_tx_meas_sequencer.sv
// Readout measurement sequencer: drives the TX readout tone, gates RX integration and returns the decision.
// Optional macro READOUT_TX_TIMEOUT_EN adds a bounded WAIT that forces a timeout result.
module readout_tx_meas_sequencer #(
    parameter int PULSE_LENGTH   = 8,
    parameter int INTEG_DELAY    = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int QUBIT_ID_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      meas_req_valid_in,
    input  logic [QUBIT_ID_WIDTH-1:0] meas_req_qubit_in,
    output logic                      meas_req_ready_out,
    output logic                      tx_pulse_en_out,
    output logic [QUBIT_ID_WIDTH-1:0] tx_qubit_out,
    output logic                      count_en_out,
    output logic                      finish_count_out,
    input  logic                      valid_meas_result_in,
    input  logic                      meas_result_in,
    output logic                      result_valid_out,
    output logic                      result_out,
    output logic [QUBIT_ID_WIDTH-1:0] result_qubit_out,
    output logic                      result_timeout_out
);

    localparam int PULSE_CNT_W = $clog2(PULSE_LENGTH + 1);
    localparam logic [PULSE_CNT_W-1:0] PULSE_LAST  = PULSE_CNT_W'(PULSE_LENGTH - 1);
    localparam logic [PULSE_CNT_W-1:0] INTEG_START = PULSE_CNT_W'(INTEG_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_FINISH = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t                 state_r;
    logic [PULSE_CNT_W-1:0] pulse_cnt_r;
    logic [PULSE_CNT_W-1:0] pulse_next_s;

`ifdef READOUT_TX_TIMEOUT_EN
    localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_CNT_W-1:0] wait_cnt_r;
`else
    assign result_timeout_out = 1'b0;
`endif

    // Index of the pulse cycle that follows the current one
    assign pulse_next_s = pulse_cnt_r + 1'b1;

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            pulse_cnt_r        <= '0;
            meas_req_ready_out <= 1'b1;
            tx_pulse_en_out    <= 1'b0;
            tx_qubit_out       <= '0;
            count_en_out       <= 1'b0;
            finish_count_out   <= 1'b0;
            result_valid_out   <= 1'b0;
            result_out         <= 1'b0;
            result_qubit_out   <= '0;
`ifdef READOUT_TX_TIMEOUT_EN
            wait_cnt_r         <= '0;
            result_timeout_out <= 1'b0;
`endif
        end else begin
            // Strobes and result fields are single-cycle and zero otherwise
            finish_count_out <= 1'b0;
            result_valid_out <= 1'b0;
            result_out       <= 1'b0;
            result_qubit_out <= '0;
`ifdef READOUT_TX_TIMEOUT_EN
            result_timeout_out <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (meas_req_valid_in && meas_req_ready_out) begin
                        state_r            <= ST_PULSE;
                        meas_req_ready_out <= 1'b0;
                        tx_pulse_en_out    <= 1'b1;
                        tx_qubit_out       <= meas_req_qubit_in;
                        count_en_out       <= (INTEG_DELAY == 0);
                        pulse_cnt_r        <= '0;
                    end else begin
                        meas_req_ready_out <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_r == PULSE_LAST) begin
                        state_r          <= ST_FINISH;
                        tx_pulse_en_out  <= 1'b0;
                        count_en_out     <= 1'b0;
                        finish_count_out <= 1'b1;
                    end else begin
                        pulse_cnt_r <= pulse_next_s;
                        if (pulse_next_s == INTEG_START) begin
                            count_en_out <= 1'b1;
                        end else begin
                            count_en_out <= count_en_out;
                        end
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_WAIT;
`ifdef READOUT_TX_TIMEOUT_EN
                    wait_cnt_r <= '0;
`endif
                end
                ST_WAIT: begin
                    // A real decision takes priority over an expiring timeout
                    if (valid_meas_result_in) begin
                        state_r            <= ST_IDLE;
                        meas_req_ready_out <= 1'b1;
                        result_valid_out   <= 1'b1;
                        result_out         <= meas_result_in;
                        result_qubit_out   <= tx_qubit_out;
`ifdef READOUT_TX_TIMEOUT_EN
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r            <= ST_IDLE;
                        meas_req_ready_out <= 1'b1;
                        result_valid_out   <= 1'b1;
                        result_out         <= 1'b0;
                        result_qubit_out   <= tx_qubit_out;
                        result_timeout_out <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
`else
                    end else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                default: begin
                    state_r            <= ST_IDLE;
                    meas_req_ready_out <= 1'b1;
                    tx_pulse_en_out    <= 1'b0;
                    count_en_out       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_readout_tx_meas_sequencer.sv
// Directed bench for readout_tx_meas_sequencer: default instance plus a PULSE_LENGTH=1 instance.
// Timeout expectations follow READOUT_TX_TIMEOUT_EN when the bench is built with it.
module tb_readout_tx_meas_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0;
    logic [3:0] req_qubit = 4'd0;
    logic       rx_valid  = 1'b0;
    logic       rx_result = 1'b0;
    logic       ready, tx_en, cnt_en, finish, res_valid, res, res_to;
    logic [3:0] tx_qubit, res_qubit;

    logic       req_valid1 = 1'b0;
    logic [3:0] req_qubit1 = 4'd0;
    logic       rx_valid1  = 1'b0;
    logic       rx_result1 = 1'b0;
    logic       ready1, tx_en1, cnt_en1, finish1, res_valid1, res1, res_to1;
    logic [3:0] tx_qubit1, res_qubit1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    readout_tx_meas_sequencer dut (
        .clk(clk), .rst(rst),
        .meas_req_valid_in(req_valid), .meas_req_qubit_in(req_qubit), .meas_req_ready_out(ready),
        .tx_pulse_en_out(tx_en), .tx_qubit_out(tx_qubit), .count_en_out(cnt_en),
        .finish_count_out(finish), .valid_meas_result_in(rx_valid), .meas_result_in(rx_result),
        .result_valid_out(res_valid), .result_out(res), .result_qubit_out(res_qubit),
        .result_timeout_out(res_to)
    );

    readout_tx_meas_sequencer #(.PULSE_LENGTH(1), .INTEG_DELAY(0)) dut1 (
        .clk(clk), .rst(rst),
        .meas_req_valid_in(req_valid1), .meas_req_qubit_in(req_qubit1), .meas_req_ready_out(ready1),
        .tx_pulse_en_out(tx_en1), .tx_qubit_out(tx_qubit1), .count_en_out(cnt_en1),
        .finish_count_out(finish1), .valid_meas_result_in(rx_valid1), .meas_result_in(rx_result1),
        .result_valid_out(res_valid1), .result_out(res1), .result_qubit_out(res_qubit1),
        .result_timeout_out(res_to1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_outs", {26'd0, tx_en, cnt_en, finish, res_valid, res, res_to}, 32'd0);
        check("rst_qubits", {24'd0, tx_qubit, res_qubit}, 32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_outs1", {26'd0, tx_en1, cnt_en1, finish1, res_valid1, res1, res_to1}, 32'd0);

        // Measurement A: qubit 5, request held high the whole time
        req_valid = 1'b1;
        req_qubit = 4'd5;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check($sformatf("A_tx_c%0d", c), 32'(tx_en), 32'((c >= 1 && c <= 8) ? 1 : 0));
            check($sformatf("A_cnt_c%0d", c), 32'(cnt_en), 32'((c >= 3 && c <= 8) ? 1 : 0));
            check($sformatf("A_fin_c%0d", c), 32'(finish), 32'((c == 9) ? 1 : 0));
            check($sformatf("A_rdy_c%0d", c), 32'(ready), 32'd0);
            check($sformatf("A_resv_c%0d", c), 32'(res_valid), 32'd0);
        end
        check("A_txq", 32'(tx_qubit), 32'd5);
        rx_valid  = 1'b1;
        rx_result = 1'b1;
        tick();
        rx_valid  = 1'b0;
        rx_result = 1'b0;
        check("A_res_valid", 32'(res_valid), 32'd1);
        check("A_res", 32'(res), 32'd1);
        check("A_res_qubit", 32'(res_qubit), 32'd5);
        check("A_res_to", 32'(res_to), 32'd0);
        check("A_ready", 32'(ready), 32'd1);

        // Measurement B: the still-held request is accepted at cycle 11
        req_qubit = 4'd9;
        tick();
        req_valid = 1'b0;
        check("B_tx_j1", 32'(tx_en), 32'd1);
        check("B_txq", 32'(tx_qubit), 32'd9);
        check("B_ready_j1", 32'(ready), 32'd0);
        check("B_res_zero", {29'd0, res_valid, res, res_to}, 32'd0);
        check("B_resq_zero", 32'(res_qubit), 32'd0);
        tick();
        tick();
        rx_valid  = 1'b1;
        rx_result = 1'b1;
        tick();
        rx_valid  = 1'b0;
        rx_result = 1'b0;
        check("B_stray_rx", 32'(res_valid), 32'd0);
        check("B_tx_j4", 32'(tx_en), 32'd1);
        for (int j = 5; j <= 9; j++) tick();
        check("B_fin_j9", 32'(finish), 32'd1);
        for (int j = 10; j <= 25; j++) begin
            tick();
            check($sformatf("B_wait_resv_j%0d", j), 32'(res_valid), 32'd0);
            check($sformatf("B_wait_rdy_j%0d", j), 32'(ready), 32'd0);
        end
`ifdef READOUT_TX_TIMEOUT_EN
        tick();
        check("B_to_valid", 32'(res_valid), 32'd1);
        check("B_to_res", 32'(res), 32'd0);
        check("B_to_flag", 32'(res_to), 32'd1);
        check("B_to_qubit", 32'(res_qubit), 32'd9);
        check("B_to_ready", 32'(ready), 32'd1);
        tick();
        check("B_after_to", {30'd0, res_valid, res_to}, 32'd0);
`else
        for (int j = 26; j <= 40; j++) begin
            tick();
            check($sformatf("B_nto_j%0d", j), 32'(res_valid), 32'd0);
        end
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("B_late_valid", 32'(res_valid), 32'd1);
        check("B_late_res", 32'(res), 32'd0);
        check("B_late_to", 32'(res_to), 32'd0);
        check("B_late_qubit", 32'(res_qubit), 32'd9);
        check("B_late_ready", 32'(ready), 32'd1);
        tick();
`endif

        // Measurement C: RX valid lands on the last allowed WAIT cycle
        req_valid = 1'b1;
        req_qubit = 4'd12;
        tick();
        req_valid = 1'b0;
        for (int j = 2; j <= 25; j++) tick();
        check("C_no_early", 32'(res_valid), 32'd0);
        rx_valid  = 1'b1;
        rx_result = 1'b1;
        tick();
        rx_valid  = 1'b0;
        rx_result = 1'b0;
        check("C_valid", 32'(res_valid), 32'd1);
        check("C_res", 32'(res), 32'd1);
        check("C_to", 32'(res_to), 32'd0);
        check("C_qubit", 32'(res_qubit), 32'd12);
        tick();

        // Measurement D: reset during PULSE aborts the measurement
        req_valid = 1'b1;
        req_qubit = 4'd3;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("D_tx_c4", 32'(tx_en), 32'd1);
        check("D_cnt_c4", 32'(cnt_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("D_tx_c5", 32'(tx_en), 32'd0);
        check("D_cnt_c5", 32'(cnt_en), 32'd0);
        check("D_ready_c5", 32'(ready), 32'd1);
        check("D_txq_c5", 32'(tx_qubit), 32'd0);
        for (int c = 6; c <= 12; c++) begin
            tick();
            rx_valid = (c == 7);
            check($sformatf("D_fin_c%0d", c), 32'(finish), 32'd0);
            check($sformatf("D_resv_c%0d", c), 32'(res_valid), 32'd0);
        end
        rx_valid = 1'b0;

        // Short-pulse instance: PULSE_LENGTH=1, INTEG_DELAY=0
        req_valid1 = 1'b1;
        req_qubit1 = 4'd2;
        tick();
        req_valid1 = 1'b0;
        check("S_tx_c1", 32'(tx_en1), 32'd1);
        check("S_cnt_c1", 32'(cnt_en1), 32'd1);
        check("S_fin_c1", 32'(finish1), 32'd0);
        check("S_txq_c1", 32'(tx_qubit1), 32'd2);
        tick();
        check("S_tx_c2", 32'(tx_en1), 32'd0);
        check("S_cnt_c2", 32'(cnt_en1), 32'd0);
        check("S_fin_c2", 32'(finish1), 32'd1);
        tick();
        check("S_fin_c3", 32'(finish1), 32'd0);
        check("S_ready_c3", 32'(ready1), 32'd0);
        rx_valid1  = 1'b1;
        rx_result1 = 1'b1;
        tick();
        rx_valid1  = 1'b0;
        rx_result1 = 1'b0;
        check("S_res_valid", 32'(res_valid1), 32'd1);
        check("S_res", 32'(res1), 32'd1);
        check("S_res_qubit", 32'(res_qubit1), 32'd2);
        check("S_res_to", 32'(res_to1), 32'd0);
        check("S_ready", 32'(ready1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
